// File: rtl/controler_intersectie_if.sv
// Signal bundle between the intersection sequencer and the per-approach light modules.
// The master side is the sequencer. The slave side is the light modules, or a bench standing in for them.
interface controler_intersectie_if;
  logic       ready_N;
  logic       ready_E;
  logic       ready_S;
  logic       ready_V;
  logic       mod_noapte;
  logic [2:0] stare_semafor;
  logic       clk_div;
  logic       clk_div_int;
  logic       fault;

  modport master (
    input  ready_N,
    input  ready_E,
    input  ready_S,
    input  ready_V,
    input  mod_noapte,
    output stare_semafor,
    output clk_div,
    output clk_div_int,
    output fault
  );

  modport slave (
    output ready_N,
    output ready_E,
    output ready_S,
    output ready_V,
    output mod_noapte,
    input  stare_semafor,
    input  clk_div,
    input  clk_div_int,
    input  fault
  );
endinterface

// File: rtl/controler_intersectie.sv
// Four-approach intersection sequencer: phase code, tick/blink strobes, all-red clearance,
// per-phase watchdog and night (flashing amber) mode.
module controler_intersectie #(
  parameter int unsigned TICK_DIV       = 50_000_000,
  parameter int unsigned BLINK_HALF     = 25_000_000,
  parameter int unsigned CLEAR_TICKS    = 2,
  parameter int unsigned WATCHDOG_TICKS = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  controler_intersectie_if.master bus
);

  localparam int unsigned TW = (TICK_DIV > 1)       ? $clog2(TICK_DIV)       : 1;
  localparam int unsigned BW = (BLINK_HALF > 1)     ? $clog2(BLINK_HALF)     : 1;
  localparam int unsigned CW = (CLEAR_TICKS > 1)    ? $clog2(CLEAR_TICKS)    : 1;
  localparam int unsigned WW = (WATCHDOG_TICKS > 1) ? $clog2(WATCHDOG_TICKS) : 1;

  localparam logic [TW-1:0] TickLast  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] ClrLast   = CW'(CLEAR_TICKS - 1);
  localparam logic [WW-1:0] WdLast    = WW'(WATCHDOG_TICKS - 1);

  typedef enum logic [2:0] {
    StAllRed = 3'b000,
    StEst    = 3'b001,
    StSud    = 3'b010,
    StNord   = 3'b011,
    StVest   = 3'b100,
    StNoapte = 3'b111
  } state_e;

  function automatic state_e next_approach(input state_e cur);
    state_e nxt;
    unique case (cur)
      StNord:  nxt = StEst;
      StEst:   nxt = StSud;
      StSud:   nxt = StVest;
      default: nxt = StNord;
    endcase
    return nxt;
  endfunction

  state_e          state_q, state_d;
  state_e          ptr_q, ptr_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            clk_div_q, clk_div_d;
  logic            blink_q, blink_d;
  logic            fault_q, fault_d;
  // Bit order {V, S, E, N}; one register stage, then edge detect against the previous sample.
  logic [3:0]      rdy_q, rdy_prev_q, rdy_rise;
  logic            tick;
  logic            match;

  assign tick     = (tick_cnt_q == TickLast);
  assign rdy_rise = rdy_q & ~rdy_prev_q;

  always_comb begin
    match = 1'b0;
    unique case (state_q)
      StNord:  match = rdy_rise[0];
      StEst:   match = rdy_rise[1];
      StSud:   match = rdy_rise[2];
      StVest:  match = rdy_rise[3];
      default: match = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_cnt_d = clr_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    fault_d   = fault_q;

    unique case (state_q)
      StAllRed: begin
        if (tick) begin
          if (clr_cnt_q == ClrLast) begin
            clr_cnt_d = '0;
            state_d   = bus.mod_noapte ? StNoapte : ptr_q;
          end else begin
            clr_cnt_d = clr_cnt_q + CW'(1);
          end
        end
      end
      StNord, StEst, StSud, StVest: begin
        // A matching ready beats a watchdog expiry landing in the same cycle.
        if (match) begin
          state_d  = StAllRed;
          ptr_d    = next_approach(state_q);
          wd_cnt_d = '0;
        end else if (tick) begin
          if (wd_cnt_q == WdLast) begin
            state_d  = StNoapte;
            fault_d  = 1'b1;
            wd_cnt_d = '0;
          end else begin
            wd_cnt_d = wd_cnt_q + WW'(1);
          end
        end
      end
      StNoapte: begin
        if (!bus.mod_noapte && !fault_q) begin
          state_d = StAllRed;
          ptr_d   = StNord;
        end
      end
      default: state_d = StAllRed;
    endcase
  end

  always_comb begin
    tick_cnt_d = (tick || (state_d != state_q)) ? '0 : tick_cnt_q + TW'(1);
    // Registered from the next count so the low pulse lines up with count == TICK_DIV-1.
    clk_div_d  = (tick_cnt_d != TickLast);
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      blink_d     = blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StAllRed;
      ptr_q       <= StNord;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      clr_cnt_q   <= '0;
      wd_cnt_q    <= '0;
      clk_div_q   <= 1'b1;
      blink_q     <= 1'b0;
      fault_q     <= 1'b0;
      rdy_q       <= '0;
      rdy_prev_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      clk_div_q   <= clk_div_d;
      blink_q     <= blink_d;
      fault_q     <= fault_d;
      rdy_q       <= {bus.ready_V, bus.ready_S, bus.ready_E, bus.ready_N};
      rdy_prev_q  <= rdy_q;
    end
  end

  assign bus.stare_semafor = state_q;
  assign bus.clk_div       = clk_div_q;
  assign bus.clk_div_int   = blink_q;
  assign bus.fault         = fault_q;

endmodule

// File: tb/tb_controler_intersectie.sv
// Randomised and directed bench for controler_intersectie against a time-in-state reference model.
module tb_controler_intersectie;
  localparam int unsigned TICK_DIV       = 4;
  localparam int unsigned BLINK_HALF     = 3;
  localparam int unsigned CLEAR_TICKS    = 2;
  localparam int unsigned WATCHDOG_TICKS = 8;

  logic       clk;
  logic       rst;
  logic [3:0] rdy;    // {V, S, E, N}
  logic       night;

  controler_intersectie_if bus ();

  assign bus.ready_N    = rdy[0];
  assign bus.ready_E    = rdy[1];
  assign bus.ready_S    = rdy[2];
  assign bus.ready_V    = rdy[3];
  assign bus.mod_noapte = night;

  controler_intersectie #(
    .TICK_DIV       (TICK_DIV),
    .BLINK_HALF     (BLINK_HALF),
    .CLEAR_TICKS    (CLEAR_TICKS),
    .WATCHDOG_TICKS (WATCHDOG_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase code, next approach, sticky fault, cycles spent in the current phase,
  // cycles since reset, and the last two samples of the ready lines.
  int         m_state;
  int         m_ptr;
  int         m_fault;
  int         m_t;
  int         m_since;
  logic [3:0] m_samp;
  logic [3:0] m_prev;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int ridx(input int code);
    case (code)
      3: return 0;
      1: return 1;
      2: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int succ(input int code);
    case (code)
      3: return 1;
      1: return 2;
      2: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic bit is_approach(input int code);
    return code inside {1, 2, 3, 4};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 3;
    m_fault = 0;
    m_t     = 0;
    m_since = 0;
    m_samp  = '0;
    m_prev  = '0;
  endtask

  task automatic model_edge();
    logic [3:0] rise;
    int nxt;
    rise = m_samp & ~m_prev;
    nxt  = m_state;
    case (m_state)
      0: if (m_t == CLEAR_TICKS * TICK_DIV - 1) nxt = night ? 7 : m_ptr;
      1, 2, 3, 4: begin
        if (rise[ridx(m_state)]) begin
          nxt   = 0;
          m_ptr = succ(m_state);
        end else if (m_t == WATCHDOG_TICKS * TICK_DIV - 1) begin
          nxt     = 7;
          m_fault = 1;
        end
      end
      7: if (!night && m_fault == 0) begin
        nxt   = 0;
        m_ptr = 3;
      end
      default: ;
    endcase
    m_t     = (nxt != m_state) ? 0 : m_t + 1;
    m_state = nxt;
    m_since++;
    m_prev  = m_samp;
    m_samp  = rdy;
  endtask

  task automatic compare_all();
    check_eq("state", int'(bus.stare_semafor), m_state);
    check_eq("clk_div", int'(bus.clk_div), ((m_t % TICK_DIV) != TICK_DIV - 1) ? 1 : 0);
    check_eq("clk_div_int", int'(bus.clk_div_int), (m_since / BLINK_HALF) % 2);
    check_eq("fault", int'(bus.fault), m_fault);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks the asynchronous response.
  task automatic apply_reset();
    rdy = '0;
    #3 rst = 1'b0;
    #1;
    check_eq("rst_state", int'(bus.stare_semafor), 0);
    check_eq("rst_clk_div", int'(bus.clk_div), 1);
    check_eq("rst_blink", int'(bus.clk_div_int), 0);
    check_eq("rst_fault", int'(bus.fault), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    compare_all();
  endtask

  task automatic pulse(input int idx);
    rdy[idx] = 1'b1;
    step();
    rdy[idx] = 1'b0;
    step();
  endtask

  task automatic run_to(input int code);
    int n;
    n     = 0;
    night = 1'b0;
    while (m_state != code && n < 300) begin
      if (m_state == 7 && m_fault != 0) apply_reset();
      else if (is_approach(m_state)) pulse(ridx(m_state));
      else step();
      n++;
    end
    check_eq("reach", int'(bus.stare_semafor), code);
  endtask

  initial begin
    rst   = 1'b0;
    rdy   = '0;
    night = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    compare_all();

    // Reset release: 8 cycles of all-red, then NORD.
    repeat (12) step();
    check_eq("first_nord", int'(bus.stare_semafor), 3);

    // Full cycle, each ready six ticks into its phase.
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 40 && !is_approach(m_state); n++) step();
      repeat (6 * TICK_DIV - 1) step();
      pulse(ridx(m_state));
    end
    repeat (CLEAR_TICKS * TICK_DIV) step();
    check_eq("cycle_back_nord", int'(bus.stare_semafor), 3);

    // Non-matching readies in NORD are ignored.
    run_to(3);
    pulse(1);
    pulse(2);
    repeat (3) step();
    check_eq("wrong_ready", int'(bus.stare_semafor), 3);
    pulse(0);
    check_eq("nord_done", int'(bus.stare_semafor), 0);

    // Watchdog expiry in EST; only reset clears it.
    run_to(1);
    repeat (WATCHDOG_TICKS * TICK_DIV + 2) step();
    check_eq("wd_state", int'(bus.stare_semafor), 7);
    check_eq("wd_fault", int'(bus.fault), 1);
    night = 1'b1;
    repeat (3) step();
    night = 1'b0;
    repeat (5) step();
    check_eq("wd_sticky", int'(bus.stare_semafor), 7);
    apply_reset();

    // Night request during SUD lets the green finish.
    run_to(2);
    repeat (5) step();
    night = 1'b1;
    repeat (5) step();
    check_eq("night_sud_holds", int'(bus.stare_semafor), 2);
    pulse(2);
    check_eq("night_allred", int'(bus.stare_semafor), 0);
    repeat (CLEAR_TICKS * TICK_DIV) step();
    check_eq("night_enter", int'(bus.stare_semafor), 7);
    night = 1'b0;
    step();
    check_eq("night_exit", int'(bus.stare_semafor), 0);
    repeat (CLEAR_TICKS * TICK_DIV) step();
    check_eq("night_to_nord", int'(bus.stare_semafor), 3);

    // Ready edge lands on the watchdog expiry tick in VEST, then stays high.
    run_to(4);
    for (int n = 0; n < 60 && m_t != WATCHDOG_TICKS * TICK_DIV - 2; n++) step();
    rdy[3] = 1'b1;
    step();
    step();
    check_eq("race_state", int'(bus.stare_semafor), 0);
    check_eq("race_fault", int'(bus.fault), 0);
    repeat (8) step();
    rdy[3] = 1'b0;
    repeat (4) step();
    check_eq("one_advance", int'(bus.stare_semafor), 3);

    // Random traffic with varying ready density, night toggles and occasional resets.
    for (int seg = 0; seg < 15; seg++) begin
      int dens;
      dens = $urandom_range(0, 2);
      for (int c = 0; c < 200; c++) begin
        for (int b = 0; b < 4; b++) begin
          case (dens)
            0:       rdy[b] = ($urandom_range(0, 3) == 0);
            1:       rdy[b] = ($urandom_range(0, 59) == 0);
            default: rdy[b] = 1'b0;
          endcase
        end
        if ($urandom_range(0, 99) == 0) night = ~night;
        if ($urandom_range(0, 399) == 0 || (m_fault != 0 && $urandom_range(0, 49) == 0))
          apply_reset();
        else
          step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
